// File: rtl/wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_cmd_master: single-transfer Wishbone classic initiator, cmd/rsp I/F   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_timeout_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic [15:0] txn_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Counter value on the last stb cycle before the transfer is abandoned.
  localparam logic [TIMEOUT_W-1:0] C_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic [31:0]          rsp_dat_q;
  logic                 rsp_timeout_q;
  logic                 cyc_q;
  logic                 stb_q;
  logic                 we_q;
  logic [31:0]          adr_q;
  logic [31:0]          dat_q;
  logic [3:0]           sel_q;
  logic                 busy_q;
  logic [15:0]          txn_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      tmo_cnt_q     <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= 32'h0;
      rsp_timeout_q <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= 32'h0;
      dat_q         <= 32'h0;
      sel_q         <= 4'h0;
      busy_q        <= 1'b0;
      txn_q         <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            tmo_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_BUS;
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack on the timeout edge completes normally.
          if (wbm_ack_i) begin
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            rsp_dat_q     <= we_q ? 32'h0 : wbm_dat_i;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            txn_q         <= txn_q + 16'd1;
            state_q       <= S_RESP;
          end else if (tmo_cnt_q == C_TMO_LAST) begin
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            rsp_dat_q     <= 32'h0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = stb_q;
  assign wbm_we_o      = we_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = sel_q;
  assign busy_o        = busy_q;
  assign txn_count_o   = txn_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_cmd_master: vector table + scoreboard bench for wb_cmd_master      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_to;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [31:0] wbm_adr, wbm_dat;
  logic [3:0]  wbm_sel;
  logic        busy;
  logic [15:0] txn;

  logic        force_ack = 1'b0;
  int          ack_delay = 99;
  logic [31:0] slave_rdat = 32'h0;
  int          stb_age = 0;
  int          cyc_cnt = 0;
  logic        wbm_ack;

  assign wbm_ack = force_ack | (wbm_cyc && wbm_stb && (stb_age == ack_delay));

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_timeout_o(rsp_to),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
    .wbm_dat_i(slave_rdat), .wbm_ack_i(wbm_ack),
    .busy_o(busy), .txn_count_o(txn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave: acks in stb cycle (ack_delay + 1).
  always @(posedge clk or posedge rst) begin
    if (rst) stb_age <= 0;
    else     stb_age <= (wbm_cyc && wbm_stb) ? stb_age + 1 : 0;
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_to;
    int          exp_stb;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] rdat;
    int          rsp_wait;
    logic [31:0] exp_dat;
    logic        exp_to;
    int          exp_stb;
  } vec_t;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t drv_exp;
  exp_t cur;
  int   stb_cycles = 0;
  logic [15:0] exp_txn = 16'h0;
  logic prev_ack = 1'b0;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: pushes on accept, checks bus hold, pops on response handshake.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      stb_cycles = 0;
      exp_txn    = 16'h0;
      prev_ack   = 1'b0;
    end else begin
      if (prev_ack) chk("rsp_after_ack", {63'h0, wbm_cyc, rsp_valid}, 64'h1);
      prev_ack = wbm_cyc && wbm_stb && wbm_ack;
      if (cmd_valid && cmd_ready) sb.push_back(drv_exp);
      if (wbm_cyc && wbm_stb) begin
        stb_cycles++;
        if (sb.size() == 0) fail_now("stb_without_cmd");
        else begin
          chk("wbm_adr_hold", wbm_adr, sb[0].adr);
          chk("wbm_ctl_hold", {wbm_we, wbm_sel, wbm_dat}, {sb[0].we, sb[0].sel, sb[0].dat});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) fail_now("rsp_without_cmd");
        else begin
          cur = sb.pop_front();
          if (!cur.exp_to) exp_txn = exp_txn + 16'd1;
          chk("rsp_dat", rsp_dat, cur.exp_dat);
          chk("rsp_timeout", rsp_to, cur.exp_to);
          chk("txn_count", txn, exp_txn);
          chk("stb_cycles", stb_cycles, cur.exp_stb);
        end
        stb_cycles = 0;
      end
    end
  end

  task automatic set_cmd(input vec_t v);
    cmd_we     = v.we;
    cmd_adr    = v.adr;
    cmd_dat    = v.dat;
    cmd_sel    = v.sel;
    ack_delay  = v.delay;
    slave_rdat = v.rdat;
    drv_exp    = '{v.we, v.adr, v.dat, v.sel, v.exp_dat, v.exp_to, v.exp_stb};
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 100);
    if (k >= 100) fail_now(name);
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 100);
    if (k >= 100) fail_now(name);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    set_cmd(v);
    cmd_valid = 1'b1;
    wait_ready("accept_bound");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp("rsp_bound");
    repeat (v.rsp_wait) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_to, rsp_dat}, {1'b1, v.exp_to, v.exp_dat});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    fail_now("global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   t0, t1;
    vec_t va, vb;
    //           we    adr           dat           sel  dly rdat          wait exp_dat       to    stb
    vecs[0] = '{1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 1, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 32'h0000_005A, 0, 32'h0000_005A, 1'b0, 2};
    vecs[2] = '{1'b0, 32'h3000_0004, 32'h1111_2222, 4'h3, 5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 6};
    vecs[3] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 99, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1, TMO};
    vecs[4] = '{1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, TMO-1, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, TMO};
    vecs[5] = '{1'b1, 32'h3000_0010, 32'h8765_4321, 4'h5, 0, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b0, 1};
    vecs[6] = '{1'b0, 32'h3000_0014, 32'h0000_0000, 4'h8, 2, 32'hCAFE_0001, 10, 32'hCAFE_0001, 1'b0, 3};
    vecs[7] = '{1'b1, 32'h3000_0018, 32'h5555_AAAA, 4'hF, 99, 32'hFFFF_FFFF, 4, 32'h0000_0000, 1'b1, TMO};
    vecs[8] = '{1'b0, 32'h3000_001C, 32'h0000_0000, 4'h1, 0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 1};

    #1;
    chk("reset_ctl", {cmd_ready, rsp_valid, rsp_to, wbm_cyc, wbm_stb, wbm_we, busy}, 7'h0);
    chk("reset_data", {rsp_dat, wbm_adr}, 64'h0);
    chk("reset_txn", txn, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {cmd_ready, busy, rsp_valid}, 3'b100);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stray ack two cycles after a timeout must be ignored.
    run_vec(vecs[3]);
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", {wbm_cyc, busy, rsp_valid, cmd_ready}, 4'b0001);
    chk("stray_ack_txn", txn, exp_txn);

    // Pending response blocks a second valid command.
    va = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0000_0077, 0, 32'h0000_0077, 1'b0, 1};
    vb = '{1'b1, 32'h3000_0024, 32'hA5A5_0F0F, 4'hC, 0, 32'h0000_0077, 0, 32'h0, 1'b0, 1};
    @(posedge clk); #1;
    set_cmd(va);
    cmd_valid = 1'b1;
    wait_ready("bp_accept_a");
    @(posedge clk); #1;
    set_cmd(vb);
    wait_rsp("bp_rsp_a");
    repeat (10) begin
      @(negedge clk);
      chk("bp_no_accept", {rsp_valid, rsp_dat, cmd_ready, wbm_cyc}, {1'b1, 32'h0000_0077, 1'b0, 1'b0});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_ready("bp_accept_b");
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Back-to-back commands with the response always consumed: 3-cycle spacing.
    va = '{1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h0000_1234, 0, 32'h0000_1234, 1'b0, 1};
    vb = '{1'b0, 32'h3000_0034, 32'h0, 4'hF, 0, 32'h0000_1234, 0, 32'h0000_1234, 1'b0, 1};
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_cmd(va);
    cmd_valid = 1'b1;
    wait_ready("b2b_accept_a");
    t0 = cyc_cnt;
    @(posedge clk); #1;
    set_cmd(vb);
    wait_ready("b2b_accept_b");
    t1 = cyc_cnt;
    chk("b2b_spacing", t1 - t0, 3);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Asynchronous reset while stb is high.
    va = '{1'b0, 32'h3000_0040, 32'h0, 4'hF, 99, 32'h0, 0, 32'h0, 1'b1, TMO};
    @(posedge clk); #1;
    set_cmd(va);
    cmd_valid = 1'b1;
    wait_ready("rst_accept");
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_stb", {wbm_cyc, wbm_stb}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_drop", {wbm_cyc, wbm_stb, rsp_valid, busy, cmd_ready}, 5'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_release_state", {cmd_ready, rsp_valid, busy, wbm_cyc}, 4'b1000);
    chk("rst_release_txn", txn, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
